// File: rtl/pwm_level_controller_if.sv
// Signal bundle between the PWM level controller and its surroundings:
// raw buttons and converter digits in, level, PWM and display scan out.
interface pwm_level_controller_if;
    logic       btn_up;
    logic       btn_down;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] level;
    logic       level_change;
    logic       pwm_out;
    logic [3:0] scan_digit;
    logic [2:0] scan_sel;

    // Environment side: drives buttons and converter digits, observes outputs.
    modport master (
        output btn_up, btn_down, digit0, digit1, digit2,
        input  level, level_change, pwm_out, scan_digit, scan_sel
    );

    // Controller side.
    modport slave (
        input  btn_up, btn_down, digit0, digit1, digit2,
        output level, level_change, pwm_out, scan_digit, scan_sel
    );
endinterface

// File: rtl/pwm_level_controller.sv
// Two-button duty-level controller (0..10) driving a 10-step PWM output and a
// three-digit multiplexed display scanner fed by an external BCD converter.
module pwm_level_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned PWM_PRESCALE    = 1000,
    parameter int unsigned SCAN_CYCLES     = 50000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pwm_level_controller_if.slave  bus
);

    localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned PS_W  = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
    localparam int unsigned SC_W  = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int unsigned LVL_W = 4;
    localparam int unsigned STP_W = 4;

    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PS_W-1:0]  PS_LAST   = PS_W'(PWM_PRESCALE - 1);
    localparam logic [SC_W-1:0]  SC_LAST   = SC_W'(SCAN_CYCLES - 1);
    localparam logic [LVL_W-1:0] LVL_MAX   = LVL_W'(10);
    localparam logic [STP_W-1:0] STEP_LAST = STP_W'(9);

    // ------------------------------------------------------------------
    // Button conditioning: bit 0 = up, bit 1 = down.
    // ------------------------------------------------------------------
    logic [1:0]            sync1_q;
    logic [1:0]            sync2_q;
    logic [1:0][DB_W-1:0]  db_cnt_q;
    logic [1:0][DB_W-1:0]  db_cnt_d;
    logic [1:0]            db_state_q;
    logic [1:0]            db_state_d;
    logic [1:0]            db_prev_q;
    logic [1:0]            press_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            db_cnt_q   <= '0;
            db_state_q <= '0;
            db_prev_q  <= '0;
        end else begin
            sync1_q    <= {bus.btn_down, bus.btn_up};
            sync2_q    <= sync1_q;
            db_cnt_q   <= db_cnt_d;
            db_state_q <= db_state_d;
            db_prev_q  <= db_state_q;
        end
    end

    // A change is accepted only after DEBOUNCE_CYCLES consecutive mismatching cycles.
    always_comb begin
        db_cnt_d   = '0;
        db_state_d = db_state_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != db_state_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    db_state_d[i] = ~db_state_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    assign press_c = db_state_q & ~db_prev_q;

    // ------------------------------------------------------------------
    // Level register with saturation; simultaneous presses cancel.
    // ------------------------------------------------------------------
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_d;
    logic             level_change_q;
    logic             level_change_d;

    always_comb begin
        level_d        = level_q;
        level_change_d = 1'b0;
        case (press_c)
            2'b01: begin
                if (level_q < LVL_MAX) begin
                    level_d        = level_q + LVL_W'(1);
                    level_change_d = 1'b1;
                end
            end
            2'b10: begin
                if (level_q != '0) begin
                    level_d        = level_q - LVL_W'(1);
                    level_change_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q        <= '0;
            level_change_q <= 1'b0;
        end else begin
            level_q        <= level_d;
            level_change_q <= level_change_d;
        end
    end

    // ------------------------------------------------------------------
    // PWM: ten steps per period, duty latched only at period start.
    // ------------------------------------------------------------------
    logic [PS_W-1:0]  presc_q;
    logic [PS_W-1:0]  presc_d;
    logic [STP_W-1:0] step_q;
    logic [STP_W-1:0] step_d;
    logic [LVL_W-1:0] shadow_q;
    logic [LVL_W-1:0] shadow_d;
    logic             pwm_q;
    logic             pwm_d;
    logic             presc_wrap_c;
    logic             period_start_c;

    assign presc_wrap_c   = (presc_q == PS_LAST);
    assign period_start_c = presc_wrap_c && (step_q == STEP_LAST);

    always_comb begin
        presc_d  = presc_wrap_c ? '0 : presc_q + PS_W'(1);
        step_d   = step_q;
        shadow_d = shadow_q;
        if (presc_wrap_c) begin
            step_d = (step_q == STEP_LAST) ? '0 : step_q + STP_W'(1);
        end
        if (period_start_c) begin
            shadow_d = level_q;
        end
        // Compare the upcoming step so the output register lines up with it.
        pwm_d = (step_d < shadow_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q  <= '0;
            step_q   <= '0;
            shadow_q <= '0;
            pwm_q    <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            step_q   <= step_d;
            shadow_q <= shadow_d;
            pwm_q    <= pwm_d;
        end
    end

    // ------------------------------------------------------------------
    // Display scan: index 0..2 advances each slot; outputs lag index by one.
    // ------------------------------------------------------------------
    logic [SC_W-1:0] slot_q;
    logic [SC_W-1:0] slot_d;
    logic [1:0]      idx_q;
    logic [1:0]      idx_d;
    logic [2:0]      sel_q;
    logic [2:0]      sel_d;
    logic [3:0]      sdig_q;
    logic [3:0]      sdig_d;

    always_comb begin
        slot_d = (slot_q == SC_LAST) ? '0 : slot_q + SC_W'(1);
        idx_d  = idx_q;
        if (slot_q == SC_LAST) begin
            // Index 3 is never produced, but recovers to 0 if it ever appears.
            idx_d = (idx_q >= 2'd2) ? 2'd0 : idx_q + 2'd1;
        end
        sel_d  = 3'b000;
        sdig_d = 4'd0;
        case (idx_q)
            2'd0: begin
                sel_d  = 3'b001;
                sdig_d = bus.digit0;
            end
            2'd1: begin
                sel_d  = 3'b010;
                sdig_d = bus.digit1;
            end
            2'd2: begin
                sel_d  = 3'b100;
                sdig_d = bus.digit2;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
            idx_q  <= 2'd0;
            sel_q  <= 3'b001;
            sdig_q <= 4'd0;
        end else begin
            slot_q <= slot_d;
            idx_q  <= idx_d;
            sel_q  <= sel_d;
            sdig_q <= sdig_d;
        end
    end

    assign bus.level        = level_q;
    assign bus.level_change = level_change_q;
    assign bus.pwm_out      = pwm_q;
    assign bus.scan_sel     = sel_q;
    assign bus.scan_digit   = sdig_q;

endmodule

// File: tb/tb_pwm_level_controller.sv
// Self-checking bench for pwm_level_controller with small timing parameters:
// press table with scoreboard, PWM period monitor, scan and reset sequences.
module tb_pwm_level_controller;

    localparam int unsigned DB = 4;
    localparam int unsigned PS = 2;
    localparam int unsigned SC = 3;
    localparam int          HOLD = DB + 6;

    logic clk;
    logic rst_n;
    pwm_level_controller_if bus ();

    pwm_level_controller #(
        .DEBOUNCE_CYCLES (DB),
        .PWM_PRESCALE    (PS),
        .SCAN_CYCLES     (SC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required normal finish");
        $fatal(1, "watchdog");
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // External level-to-digits converter: level*10 percent in BCD.
    bit         use_conv = 1'b1;
    logic [3:0] man_d0 = 4'd0;
    logic [3:0] man_d1 = 4'd0;
    logic [3:0] man_d2 = 4'd0;

    function automatic logic [11:0] conv(input logic [3:0] lvl);
        int pct;
        pct = 32'(lvl) * 10;
        return {4'(pct / 100), 4'((pct / 10) % 10), 4'(pct % 10)};
    endfunction

    always_comb begin
        if (use_conv) {bus.digit2, bus.digit1, bus.digit0} = conv(bus.level);
        else          {bus.digit2, bus.digit1, bus.digit0} = {man_d2, man_d1, man_d0};
    end

    task automatic do_reset(input bit chk);
        rst_n = 1'b0;
        bus.btn_up = 1'b0;
        bus.btn_down = 1'b0;
        repeat (3) tick();
        if (chk) begin
            check("rst_level", int'(bus.level), 0);
            check("rst_level_change", int'(bus.level_change), 0);
            check("rst_pwm_out", int'(bus.pwm_out), 0);
            check("rst_scan_sel", int'(bus.scan_sel), 1);
            check("rst_scan_digit", int'(bus.scan_digit), 0);
        end
        rst_n = 1'b1;
    endtask

    // Clean press: hold, then release, counting level_change pulses throughout.
    task automatic press(input logic up, input logic dn, output int lvl, output int pulses);
        pulses = 0;
        bus.btn_up = up;
        bus.btn_down = dn;
        repeat (HOLD) begin
            tick();
            if (bus.level_change) pulses++;
        end
        bus.btn_up = 1'b0;
        bus.btn_down = 1'b0;
        repeat (HOLD) begin
            tick();
            if (bus.level_change) pulses++;
        end
        lvl = int'(bus.level);
    endtask

    task automatic press_n(input int n, input logic up);
        int l;
        int p;
        for (int i = 0; i < n; i++) press(up, ~up, l, p);
    endtask

    task automatic count_high(input int cycles, output int highs);
        highs = 0;
        repeat (cycles) begin
            tick();
            if (bus.pwm_out) highs++;
        end
    endtask

    task automatic wait_sel_enter(input logic [2:0] target, output bit found);
        logic [2:0] prev;
        prev = bus.scan_sel;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (bus.scan_sel == target && prev != target) found = 1'b1;
            prev = bus.scan_sel;
        end
    endtask

    // PWM period monitor: a period runs from one pwm rising edge to the next;
    // its expected high count is 2*level as seen just before that period began.
    bit mon_en = 1'b0;
    bit mon_in = 1'b0;
    bit pwm_prev = 1'b0;
    int lvl_prev = 0;
    int mon_highs = 0;
    int mon_len = 0;
    int mon_periods = 0;
    int mon_first = -1;
    int mon_last = -1;
    int psb[$];

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.pwm_out && !pwm_prev) begin
                if (mon_in) begin
                    check("pwm_period_highs", mon_highs, psb.pop_front());
                    check("pwm_period_len", mon_len, 10 * PS);
                    if (mon_periods == 0) mon_first = mon_highs;
                    mon_last = mon_highs;
                    mon_periods++;
                end
                psb.push_back(2 * PS * lvl_prev / 2);
                mon_in = 1'b1;
                mon_highs = 0;
                mon_len = 0;
            end
            if (mon_in) begin
                mon_len++;
                if (bus.pwm_out) mon_highs++;
            end
        end else begin
            mon_in = 1'b0;
            psb.delete();
        end
        pwm_prev = bus.pwm_out;
        lvl_prev = int'(bus.level);
    end

    typedef struct {
        logic up;
        logic dn;
        int   exp_level;
        int   exp_pulses;
    } press_vec_t;

    typedef struct {
        int level;
        int pulses;
    } exp_t;

    press_vec_t vecs[$];
    exp_t       sb[$];

    initial begin
        int         lvl;
        int         pulses;
        int         highs;
        bit         found;
        exp_t       e;
        press_vec_t v;
        int         exp_sel[9];
        int         exp_dig[9];

        // Press table: saturate up, saturate down, then cancelled simultaneous presses.
        for (int i = 1; i <= 11; i++) vecs.push_back('{1'b1, 1'b0, (i > 10) ? 10 : i, (i > 10) ? 0 : 1});
        for (int i = 1; i <= 11; i++) vecs.push_back('{1'b0, 1'b1, (i > 10) ? 0 : 10 - i, (i > 10) ? 0 : 1});
        vecs.push_back('{1'b1, 1'b1, 0, 0});
        vecs.push_back('{1'b1, 1'b0, 1, 1});
        vecs.push_back('{1'b1, 1'b1, 1, 0});
        vecs.push_back('{1'b0, 1'b1, 0, 1});

        exp_sel = '{2, 2, 2, 4, 4, 4, 1, 1, 1};
        exp_dig = '{1, 1, 1, 0, 0, 0, 0, 0, 0};

        do_reset(1'b1);

        // Held button: level changes at the 7th edge, pulse lasts one cycle.
        bus.btn_up = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("hold_level_e%0d", k), int'(bus.level), (k >= 7) ? 1 : 0);
            check($sformatf("hold_change_e%0d", k), int'(bus.level_change), (k == 7) ? 1 : 0);
        end
        bus.btn_up = 1'b0;
        repeat (12) tick();

        // Short bounce: three cycles high is rejected.
        pulses = 0;
        bus.btn_up = 1'b1;
        repeat (3) tick();
        bus.btn_up = 1'b0;
        repeat (12) begin
            tick();
            if (bus.level_change) pulses++;
        end
        check("short_pulse_level", int'(bus.level), 1);
        check("short_pulse_changes", pulses, 0);

        do_reset(1'b0);
        foreach (vecs[i]) begin
            v = vecs[i];
            sb.push_back('{v.exp_level, v.exp_pulses});
            press(v.up, v.dn, lvl, pulses);
            e = sb.pop_front();
            check($sformatf("tbl%0d_level", i), lvl, e.level);
            check($sformatf("tbl%0d_pulses", i), pulses, e.pulses);
        end

        // Duty 0 stays low.
        repeat (20) tick();
        count_high(40, highs);
        check("duty0_highs", highs, 0);

        // Duty 3, then raise to 7 while periods are being measured.
        press_n(3, 1'b1);
        check("pwm_level3", int'(bus.level), 3);
        mon_en = 1'b1;
        repeat (25) tick();
        press_n(4, 1'b1);
        check("pwm_level7", int'(bus.level), 7);
        repeat (80) tick();
        mon_en = 1'b0;
        check("pwm_first_period_highs", mon_first, 6);
        check("pwm_last_period_highs", mon_last, 14);
        check("pwm_enough_periods", int'(mon_periods >= 6), 1);

        // Duty 10 stays high.
        press_n(3, 1'b1);
        check("pwm_level10", int'(bus.level), 10);
        repeat (25) tick();
        count_high(40, highs);
        check("duty10_highs", highs, 40);

        // Scan order and digit routing at level 1 (digits 0/1/0).
        do_reset(1'b0);
        press_n(1, 1'b1);
        wait_sel_enter(3'b010, found);
        check("scan_found_tens", int'(found), 1);
        for (int j = 0; j < 9; j++) begin
            if (j > 0) tick();
            check($sformatf("scan_sel_%0d", j), int'(bus.scan_sel), exp_sel[j]);
            check($sformatf("scan_digit_%0d", j), int'(bus.scan_digit), exp_dig[j]);
        end

        // Digit change inside a slot shows up one cycle later.
        wait_sel_enter(3'b010, found);
        check("scan_found_tens2", int'(found), 1);
        check("track_digit_before", int'(bus.scan_digit), 1);
        man_d0 = 4'd0;
        man_d1 = 4'd9;
        man_d2 = 4'd0;
        use_conv = 1'b0;
        tick();
        check("track_digit_next", int'(bus.scan_digit), 9);
        check("track_sel_next", int'(bus.scan_sel), 2);
        tick();
        check("track_digit_hold", int'(bus.scan_digit), 9);
        tick();
        check("track_sel_hundreds", int'(bus.scan_sel), 4);
        check("track_digit_hundreds", int'(bus.scan_digit), 0);
        use_conv = 1'b1;

        // Asynchronous reset during a held press at level 5.
        do_reset(1'b0);
        press_n(5, 1'b1);
        check("rst_mid_level5", int'(bus.level), 5);
        repeat (20) tick();
        bus.btn_up = 1'b1;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_level", int'(bus.level), 0);
        check("async_rst_change", int'(bus.level_change), 0);
        check("async_rst_pwm", int'(bus.pwm_out), 0);
        check("async_rst_sel", int'(bus.scan_sel), 1);
        check("async_rst_digit", int'(bus.scan_digit), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k >= 6) begin
                check($sformatf("post_rst_level_e%0d", k), int'(bus.level), (k >= 7) ? 1 : 0);
                check($sformatf("post_rst_change_e%0d", k), int'(bus.level_change), (k == 7) ? 1 : 0);
            end
        end
        bus.btn_up = 1'b0;
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
